// File: rtl/audio_level_meter.sv
// audio_level_meter
//   Turns a stream of 10-bit offset-binary ADC samples into a peak-hold
//   level and a lit-LED count, producing one result per window of WIN_LEN
//   samples.
//
//   Pipeline: magnitude about midscale -> window peak -> peak-hold with
//   exponential decay -> scale to 0..NUM_LEDS LEDs.
//
//   Optional build macro AUDIO_LEVEL_DC_TRACK_EN: when defined, the fixed
//   midscale (512) is replaced by a slowly tracked DC estimate. Ports are
//   identical in both builds.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   sample_valid  single-cycle pulse, sample is valid this cycle
//   sample        unsigned offset-binary ADC code
//   level_valid   single-cycle strobe, level/led_count updated this cycle
//   level         held magnitude, 0..511
//   led_count     number of LEDs to light, 0..NUM_LEDS
//   busy          output FSM is not idle
//   overrun       sticky, a window closed while the FSM was busy
module audio_level_meter #(
  parameter int DATA_W      = 10,
  parameter int WIN_LEN     = 64,
  parameter int NUM_LEDS    = 30,
  parameter int LED_W       = 6,
  parameter int DECAY_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              level_valid,
  output logic [8:0]        level,
  output logic [LED_W-1:0]  led_count,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(WIN_LEN);
  localparam int PROD_W = 9 + LED_W;

  typedef enum logic [1:0] {WAIT, DECAY, SCALE, EMIT} state_t;

  state_t state, state_nx;

  // ---------------------------------------------------------------------
  // Magnitude about the midscale reference
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mid;

`ifdef AUDIO_LEVEL_DC_TRACK_EN
  // dc holds the estimate with 6 fractional bits; first-order IIR, alpha=1/64.
  logic [15:0]        dc;
  logic signed [16:0] dc_err;

  assign mid    = dc[15:6];
  assign dc_err = $signed({1'b0, sample, 6'b0}) - $signed({1'b0, dc});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc <= 16'(512 << 6);
    end else if (sample_valid) begin
      dc <= dc + 16'(dc_err >>> 6);
    end
  end
`else
  assign mid = DATA_W'(1 << (DATA_W - 1));
`endif

  logic signed [DATA_W:0] centered;
  logic [DATA_W:0]        abs_c;
  logic [8:0]             mag;

  assign centered = $signed({1'b0, sample}) - $signed({1'b0, mid});
  assign abs_c    = centered[DATA_W] ? (DATA_W+1)'(-centered) : $unsigned(centered);
  assign mag      = (abs_c > (DATA_W+1)'(511)) ? 9'd511 : abs_c[8:0];

  // ---------------------------------------------------------------------
  // Window accumulator (independent of the output FSM)
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] win_cnt;
  logic [8:0]       win_peak;
  logic [8:0]       peak_nx;
  logic             win_close;

  assign peak_nx   = (mag > win_peak) ? mag : win_peak;
  assign win_close = sample_valid && (win_cnt == CNT_W'(WIN_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt  <= '0;
      win_peak <= '0;
    end else if (sample_valid) begin
      if (win_close) begin
        win_cnt  <= '0;
        win_peak <= '0;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        win_peak <= peak_nx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FSM: WAIT -> DECAY -> SCALE -> EMIT -> WAIT
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT:    if (win_close) state_nx = DECAY;
      DECAY:   state_nx = SCALE;
      SCALE:   state_nx = EMIT;
      EMIT:    state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  assign busy = (state != WAIT);

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  logic [8:0]        snapshot;
  logic [8:0]        held;
  logic [LED_W-1:0]  cnt_q;
  logic [8:0]        decayed;
  logic [8:0]        held_nx;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] cnt_full;
  logic [LED_W-1:0]  scaled;

  assign decayed  = held - (held >> DECAY_SHIFT);
  assign held_nx  = (snapshot > decayed) ? snapshot : decayed;
  assign prod     = PROD_W'(held) * PROD_W'(NUM_LEDS + 1);
  assign cnt_full = prod >> 9;
  assign scaled   = (cnt_full > PROD_W'(NUM_LEDS)) ? LED_W'(NUM_LEDS) : cnt_full[LED_W-1:0];

  // Outputs are registered on the EMIT->WAIT edge so level/led_count and
  // the strobe change together, three edges after the closing sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot    <= '0;
      held        <= '0;
      cnt_q       <= '0;
      level       <= '0;
      led_count   <= '0;
      level_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (win_close) begin
        if (state == WAIT) snapshot <= peak_nx;
        else               overrun  <= 1'b1;
      end
      case (state)
        DECAY: held <= held_nx;
        SCALE: cnt_q <= scaled;
        EMIT: begin
          level       <= held;
          led_count   <= cnt_q;
          level_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter
//   Scoreboarded bench for audio_level_meter. Two instances share clock and
//   reset: dut0 with default parameters and dut1 with WIN_LEN=2 for the
//   back-to-back window case. A behavioural model predicts each result when
//   a window closes and queues it; a negedge monitor pops and compares when
//   the DUT strobes level_valid, and also checks busy/overrun/hold each cycle.
module tb_audio_level_meter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sv0 = 1'b0, sv1 = 1'b0;
  logic [9:0] s0 = '0, s1 = '0;

  logic       lv0, lv1, busy0, busy1, ovr0, ovr1;
  logic [8:0] lvl0, lvl1;
  logic [5:0] led0, led1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  audio_level_meter #(.DATA_W(10), .WIN_LEN(64), .NUM_LEDS(30), .LED_W(6), .DECAY_SHIFT(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .sample_valid(sv0), .sample(s0),
    .level_valid(lv0), .level(lvl0), .led_count(led0), .busy(busy0), .overrun(ovr0));

  audio_level_meter #(.DATA_W(10), .WIN_LEN(2), .NUM_LEDS(30), .LED_W(6), .DECAY_SHIFT(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .sample_valid(sv1), .sample(s1),
    .level_valid(lv1), .level(lvl1), .led_count(led1), .busy(busy1), .overrun(ovr1));

  typedef struct {int lvl; int led; int due;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  int win_len [2] = '{64, 2};
  int m_cnt [2], m_peak [2], m_held [2], m_last [2], m_dc [2], m_lvl [2], m_led [2];
  bit m_ovr [2];

  task automatic cmp(input string name, input int k, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, k, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_peak[k] = 0; m_held[k] = 0; m_last[k] = -100;
      m_dc[k] = 512 * 64; m_lvl[k] = 0; m_led[k] = 0; m_ovr[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One sample as seen at clock edge number cyc.
  task automatic model_sample(input int k, input int s);
    int c, m, led;
    exp_t e;
`ifdef AUDIO_LEVEL_DC_TRACK_EN
    c = s - (m_dc[k] >>> 6);
    m_dc[k] = m_dc[k] + (((s * 64) - m_dc[k]) >>> 6);
`else
    c = s - 512;
`endif
    m = (c < 0) ? -c : c;
    if (m > 511) m = 511;
    if (m > m_peak[k]) m_peak[k] = m;
    m_cnt[k]++;
    if (m_cnt[k] == win_len[k]) begin
      if (cyc >= m_last[k] + 4) begin
        m_held[k] = m_held[k] - m_held[k] / 8;
        if (m_peak[k] > m_held[k]) m_held[k] = m_peak[k];
        led = (m_held[k] * 31) / 512;
        if (led > 30) led = 30;
        e = '{m_held[k], led, cyc + 3};
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        m_last[k] = cyc;
      end else begin
        m_ovr[k] = 1'b1;
      end
      m_peak[k] = 0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic step(input int k, input bit v, input int s);
    @(negedge clk);
    sv0 = (k == 0) && v;
    s0  = (k == 0) ? 10'(s) : 10'd0;
    sv1 = (k == 1) && v;
    s1  = (k == 1) ? 10'(s) : 10'd0;
    @(posedge clk);
    #1;
    if (v && reset_n) model_sample(k, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 0);
  endtask

  task automatic check_dut(input int k, input logic v, input logic [8:0] l,
                           input logic [5:0] c, input logic b, input logic o);
    exp_t e;
    int   qs;
    cmp("busy", k, int'(b), ((cyc - m_last[k]) >= 0 && (cyc - m_last[k]) <= 2) ? 1 : 0);
    cmp("overrun", k, int'(o), int'(m_ovr[k]));
    if (v) begin
      qs = (k == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        cmp("unexpected_strobe", k, 1, 0);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        cmp("strobe_cycle", k, cyc, e.due);
        cmp("level", k, int'(l), e.lvl);
        cmp("led_count", k, int'(c), e.led);
        m_lvl[k] = e.lvl;
        m_led[k] = e.led;
      end
    end else begin
      cmp("level_hold", k, int'(l), m_lvl[k]);
      cmp("led_hold", k, int'(c), m_led[k]);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, lv0, lvl0, led0, busy0, ovr0);
    check_dut(1, lv1, lvl1, led1, busy1, ovr1);
  end

  // Safety net against an unexpectedly stuck run.
  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    sv0 = 1'b0;
    sv1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int pos;
    model_reset();

    // Reset held low for two cycles while sample_valid toggles.
    repeat (2) begin
      @(negedge clk);
      sv0 = ~sv0;
      sv1 = ~sv1;
      s0  = 10'd1023;
      s1  = 10'd0;
    end
    @(negedge clk);
    sv0 = 1'b0;
    sv1 = 1'b0;
    #1;
    cmp("reset_outputs", 0, {lv0, lvl0, led0, busy0, ovr0} == '0 ? 0 : 1, 0);
    cmp("reset_outputs", 1, {lv1, lvl1, led1, busy1, ovr1} == '0 ? 0 : 1, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Partial window then reset: the partial data must be discarded.
    for (int i = 0; i < 10; i++) step(0, 1'b1, int'($urandom_range(0, 1023)));
    do_reset();
    for (int i = 0; i < 64; i++) step(0, 1'b1, 512);
    idle(8);

    // Quiet window with sparse samples.
    for (int i = 0; i < 64; i++) begin
      step(0, 1'b1, 512);
      idle(11);
    end
    idle(6);

    // Full scale, once with 1023 and once with 0 at a random position.
    for (int pass = 0; pass < 2; pass++) begin
      pos = int'($urandom_range(0, 63));
      for (int i = 0; i < 64; i++) begin
        step(0, 1'b1, (i == pos) ? ((pass == 0) ? 1023 : 0) : 512);
        idle(int'($urandom_range(0, 2)));
      end
      idle(6);
    end

    // Two quiet windows: held level decays 511 -> 448 -> 392.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) step(0, 1'b1, 512);
      idle(6);
    end

    // Constant offset input.
    for (int i = 0; i < 2000; i++) begin
      step(0, 1'b1, 600);
      idle(1);
    end
    idle(6);

    // Random windows with random sample spacing.
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 64; i++) begin
        step(0, 1'b1, int'($urandom_range(0, 1023)));
        idle(int'($urandom_range(0, 1)));
      end
    end
    idle(8);

    // Back-to-back windows on the WIN_LEN=2 instance.
    for (int i = 0; i < 24; i++) step(1, 1'b1, (i % 2 == 0) ? 1023 : 512);
    for (int i = 0; i < 16; i++) step(1, 1'b1, int'($urandom_range(0, 1023)));
    idle(10);

    cmp("pending_results", 0, q0.size(), 0);
    cmp("pending_results", 1, q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
